// File: rtl/tc_pkg.sv
// Shared tensor-core package: dimensions, tile framing,
// loader state encoding and operand-matrix select codes.
package tc_pkg;

  localparam int DIM            = 4;
  localparam int EW             = 8;
  localparam int BEATS_PER_TILE = 12;
  localparam int CNT_W          = 4;

  localparam logic [CNT_W-1:0] LAST_BEAT =
    CNT_W'(BEATS_PER_TILE - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL
  } state_t;

  typedef enum logic [1:0] {
    MAT_A = 2'd0,
    MAT_B = 2'd1,
    MAT_C = 2'd2
  } mat_sel_t;

endpackage

// File: rtl/tc_fp8_operand_loader.sv
// FP8 operand loader: assembles a 12-beat A/B/C row stream into
// 4x4 operand arrays and holds them with tile_valid until taken.
// Ports: clk, rst_n, flush; s_valid/s_ready/s_data/s_last input
// stream; A/B/C operand matrices; tile_valid/tile_ready; err pulse.
module tc_fp8_operand_loader
  import tc_pkg::*;
#(
  parameter int DIM = 4,
  parameter int EW  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DIM*EW-1:0]             s_data,
  input  logic                          s_last,
  output logic [0:DIM-1][0:DIM-1][EW-1:0] A,
  output logic [0:DIM-1][0:DIM-1][EW-1:0] B,
  output logic [0:DIM-1][0:DIM-1][EW-1:0] C,
  output logic                          tile_valid,
  input  logic                          tile_ready,
  output logic                          err
);

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic             acc;
  logic             wr_en;
  mat_sel_t         sel;
  logic [1:0]       row;

  assign acc   = s_valid && s_ready && (state == FILL);
  // A beat arriving together with flush is dropped.
  assign wr_en = acc && !flush;
  assign sel   = mat_sel_t'(beat_cnt[3:2]);
  assign row   = beat_cnt[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      s_ready    <= 1'b0;
      tile_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      if (flush) begin
        state      <= FILL;
        beat_cnt   <= '0;
        s_ready    <= 1'b1;
        tile_valid <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state   <= FILL;
            s_ready <= 1'b1;
          end
          FILL: begin
            if (acc) begin
              if (beat_cnt == LAST_BEAT) begin
                // Completion is count-driven;
                // a missing s_last only flags.
                state      <= FULL;
                beat_cnt   <= '0;
                s_ready    <= 1'b0;
                tile_valid <= 1'b1;
                err        <= !s_last;
              end else if (s_last) begin
                beat_cnt <= '0;
                err      <= 1'b1;
              end else begin
                beat_cnt <= beat_cnt + 1'b1;
              end
            end
          end
          FULL: begin
            if (tile_ready) begin
              state      <= FILL;
              s_ready    <= 1'b1;
              tile_valid <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            s_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A <= '0;
      B <= '0;
      C <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < DIM; k++) begin
        unique case (1'b1)
          (sel == MAT_A): A[row][k] <= s_data[EW*k +: EW];
          (sel == MAT_B): B[row][k] <= s_data[EW*k +: EW];
          (sel == MAT_C): C[row][k] <= s_data[EW*k +: EW];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tc_fp8_operand_loader.sv
// Directed bench for tc_fp8_operand_loader: nominal, hold,
// gaps, framing errors, flush and mid-tile reset.
module tb_tc_fp8_operand_loader;
  import tc_pkg::*;

  typedef logic [0:3][0:3][7:0] mat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        tile_ready = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic        tile_valid;
  logic        err;
  mat_t        A;
  mat_t        B;
  mat_t        C;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tc_fp8_operand_loader #(.DIM(4), .EW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .A          (A),
    .B          (B),
    .C          (C),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .err        (err)
  );

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic mat_t exp_mat(input int base, input bit mix);
    mat_t m;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++)
        m[i][k] = 8'(base + i + (mix ? 32 * k : 0));
    return m;
  endfunction

  task automatic send_beat(input int n, input int base,
                           input bit mix, input bit last);
    int w = 0;
    @(negedge clk);
    while (!s_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) check("s_ready_timeout", 0, 1);
    s_valid = 1'b1;
    s_last  = last;
    for (int k = 0; k < 4; k++)
      s_data[8*k +: 8] = 8'(base + n + (mix ? 32 * k : 0));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_mats(input string tag, input int base,
                            input bit mix);
    check({tag, "_A"}, A, exp_mat(base, mix));
    check({tag, "_B"}, B, exp_mat(base + 4, mix));
    check({tag, "_C"}, C, exp_mat(base + 8, mix));
  endtask

  task automatic send_tile(input string tag, input int base,
                           input bit mix, input bit last_ok,
                           input int gap_max);
    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_beat(n, base, mix, (n == 11) && last_ok);
      check($sformatf("%s_err_b%0d", tag, n), err,
            128'((n == 11) && !last_ok));
      check($sformatf("%s_tv_b%0d", tag, n), tile_valid,
            128'(n == 11));
    end
    check({tag, "_rdy_hold"}, s_ready, 0);
    check_mats(tag, base, mix);
  endtask

  task automatic release_tile(input string tag);
    @(negedge clk);
    tile_ready = 1'b1;
    @(posedge clk);
    #1;
    tile_ready = 1'b0;
    check({tag, "_rel_tv"}, tile_valid, 0);
    check({tag, "_rel_rdy"}, s_ready, 1);
  endtask

  initial begin
    #12;
    check("rst_rdy", s_ready, 0);
    check("rst_tv", tile_valid, 0);
    check("rst_err", err, 0);
    check("rst_A", A, 0);
    check("rst_B", B, 0);
    check("rst_C", C, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_rdy", s_ready, 1);

    send_tile("nom", 0, 1'b0, 1'b1, 0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("hold_A", A, exp_mat(0, 1'b0));
      check("hold_B", B, exp_mat(4, 1'b0));
      check("hold_C", C, exp_mat(8, 1'b0));
      check("hold_tv", tile_valid, 1);
      check("hold_rdy", s_ready, 0);
    end
    release_tile("nom");
    send_tile("second", 16, 1'b1, 1'b1, 0);
    release_tile("second");

    send_tile("gaps", 0, 1'b0, 1'b1, 3);
    release_tile("gaps");

    for (int n = 0; n < 6; n++) begin
      send_beat(n, 100, 1'b0, n == 5);
      check($sformatf("early_err_b%0d", n), err, 128'(n == 5));
      check("early_tv", tile_valid, 0);
    end
    @(posedge clk);
    #1;
    check("early_err_clr", err, 0);
    send_tile("early", 48, 1'b1, 1'b1, 0);
    release_tile("early");

    send_tile("miss", 64, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
    check("miss_err_clr", err, 0);
    release_tile("miss");

    for (int n = 0; n < 7; n++) send_beat(n, 120, 1'b0, 1'b0);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 32'h7f7f7f7f;
    flush   = 1'b1;
    @(posedge clk);
    #1;
    flush   = 1'b0;
    s_valid = 1'b0;
    check("flush_tv", tile_valid, 0);
    check("flush_rdy", s_ready, 1);
    check("flush_err", err, 0);
    send_tile("postflush", 80, 1'b1, 1'b1, 0);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_tv", tile_valid, 0);
    check("mrst_rdy", s_ready, 0);
    check("mrst_A", A, 0);
    check("mrst_B", B, 0);
    check("mrst_C", C, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mrst_rdy_rel", s_ready, 0);
    @(posedge clk);
    #1;
    check("mrst_rdy_up", s_ready, 1);
    send_tile("recover", 8, 1'b1, 1'b1, 0);
    release_tile("recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
